// File: rtl/line_serializer_if.sv
// Bus between a line source / word sink and the line serializer.
// Valid/ready: a transfer happens on a rising clk edge where valid && ready are both 1.
// The payload must stay stable from the cycle valid rises until that edge.
interface line_serializer_if #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 8
);
    localparam int IDX_W = $clog2(WORDS);

    logic [WORD_W*WORDS-1:0] line_in;
    logic                    line_valid;
    logic                    line_ready;
    logic [WORD_W-1:0]       word_out;
    logic                    word_valid;
    logic                    word_ready;
    logic [IDX_W-1:0]        word_idx;
    logic                    word_last;
    logic                    done;
    logic [1:0]              state_dbg;

    modport master (
        output line_in, line_valid, word_ready,
        input  line_ready, word_out, word_valid, word_idx, word_last, done, state_dbg
    );

    modport slave (
        input  line_in, line_valid, word_ready,
        output line_ready, word_out, word_valid, word_idx, word_last, done, state_dbg
    );
endinterface

// File: rtl/line_serializer.sv
// Sends one cache line as WORDS consecutive words, word 0 first, over a valid/ready stream.
// Every output is decoded from the state register, the shift register or the index register.
module line_serializer #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 8
) (
    input logic              clk,
    input logic              rst,
    line_serializer_if.slave bus
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int LINE_W = WORD_W * WORDS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [LINE_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            shreg <= '0;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.line_valid) begin
                        shreg <= bus.line_in;
                        idx   <= '0;
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.word_ready) begin
                        // The last word is not shifted out, so word_out holds it until the next load.
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            shreg <= shreg >> WORD_W;
                            idx   <= idx + 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.line_ready = (state == S_IDLE);
    assign bus.word_valid = (state == S_SEND);
    assign bus.done       = (state == S_DONE);
    assign bus.word_out   = shreg[WORD_W-1:0];
    assign bus.word_idx   = idx;
    assign bus.word_last  = (state == S_SEND) && (idx == LAST_IDX);
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_line_serializer.sv
// Directed and random stimulus for line_serializer, checked each cycle against a word-queue model.
module tb_line_serializer;
  localparam int WORD_W = 32;
  localparam int WORDS  = 8;
  localparam int LINE_W = WORD_W * WORDS;

  logic clk = 1'b0;
  logic rst;

  line_serializer_if #(.WORD_W(WORD_W), .WORDS(WORDS)) bus ();

  line_serializer #(.WORD_W(WORD_W), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: words of the line in flight, still to be accepted, plus a pending done cycle.
  logic [WORD_W-1:0] exp_q[$];
  bit m_done = 1'b0;
  int load_times[$];

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*WORD_W +: WORD_W] = $urandom();
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] seq_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*WORD_W +: WORD_W] = WORD_W'(i);
    return l;
  endfunction

  task automatic model_step(input logic lv, input logic wr, input logic [LINE_W-1:0] ln);
    if (m_done) begin
      m_done = 1'b0;
    end else if (exp_q.size() != 0) begin
      if (wr) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_done = 1'b1;
      end
    end else if (lv) begin
      for (int i = 0; i < WORDS; i++) exp_q.push_back(ln[i*WORD_W +: WORD_W]);
    end
  endtask

  task automatic check_outputs();
    check("line_ready", LINE_W'(bus.line_ready), LINE_W'(exp_q.size() == 0 && !m_done));
    check("word_valid", LINE_W'(bus.word_valid), LINE_W'(exp_q.size() != 0));
    check("done", LINE_W'(bus.done), LINE_W'(m_done));
    check("word_last", LINE_W'(bus.word_last), LINE_W'(exp_q.size() == 1));
    if (exp_q.size() != 0) begin
      check("word_out", LINE_W'(bus.word_out), LINE_W'(exp_q[0]));
      check("word_idx", LINE_W'(bus.word_idx), LINE_W'(WORDS - exp_q.size()));
    end
  endtask

  // One clock: inputs set before the edge are applied to the model, outputs sampled 1ns after.
  task automatic cycle();
    logic lv, wr;
    logic [LINE_W-1:0] ln;
    lv = bus.line_valid;
    wr = bus.word_ready;
    ln = bus.line_in;
    if (bus.line_ready && lv) load_times.push_back(cyc);
    @(posedge clk);
    cyc++;
    model_step(lv, wr, ln);
    #1;
    check_outputs();
  endtask

  initial begin
    int n;
    logic [LINE_W-1:0] l;

    // Reset values, asynchronously, before any clock edge
    rst = 1'b1;
    bus.line_in = '0;
    bus.line_valid = 1'b0;
    bus.word_ready = 1'b0;
    #3;
    check("rst_line_ready", LINE_W'(bus.line_ready), LINE_W'(1));
    check("rst_word_valid", LINE_W'(bus.word_valid), '0);
    check("rst_word_out", LINE_W'(bus.word_out), '0);
    check("rst_word_idx", LINE_W'(bus.word_idx), '0);
    check("rst_word_last", LINE_W'(bus.word_last), '0);
    check("rst_done", LINE_W'(bus.done), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Sequential line, one-cycle line_valid pulse, sink always ready
    bus.line_in = seq_line();
    bus.line_valid = 1'b1;
    bus.word_ready = 1'b1;
    cycle();
    bus.line_valid = 1'b0;
    repeat (11) cycle();

    // Same line, sink toggling 0,1,0,1 from the first valid word
    bus.line_valid = 1'b1;
    cycle();
    bus.line_valid = 1'b0;
    n = 0;
    while (bus.word_valid && n < 40) begin
      bus.word_ready = n[0];
      cycle();
      n++;
    end
    check("stall_span", LINE_W'(n), LINE_W'(16));
    bus.word_ready = 1'b1;
    repeat (3) cycle();

    // line_in changes and line_valid stays high during SEND
    bus.line_in = rand_line();
    bus.line_valid = 1'b1;
    cycle();
    bus.line_in = '1;
    repeat (10) cycle();
    bus.line_valid = 1'b0;
    repeat (11) cycle();

    // Back-to-back lines: loads every 10 cycles
    load_times.delete();
    bus.line_valid = 1'b1;
    repeat (30) begin
      bus.line_in = rand_line();
      cycle();
    end
    bus.line_valid = 1'b0;
    repeat (12) cycle();
    check("b2b_loads", LINE_W'(load_times.size()), LINE_W'(3));
    if (load_times.size() == 3) begin
      check("b2b_gap1", LINE_W'(load_times[1] - load_times[0]), LINE_W'(10));
      check("b2b_gap2", LINE_W'(load_times[2] - load_times[1]), LINE_W'(10));
    end

    // Asynchronous reset at word_idx 3
    bus.line_in = seq_line();
    bus.line_valid = 1'b1;
    cycle();
    bus.line_valid = 1'b0;
    n = 0;
    while (bus.word_idx != 3 && n < 20) begin
      cycle();
      n++;
    end
    check("idx3_reached", LINE_W'(n < 20), LINE_W'(1));
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_done = 1'b0;
    check("abort_word_valid", LINE_W'(bus.word_valid), '0);
    check("abort_word_out", LINE_W'(bus.word_out), '0);
    check("abort_word_idx", LINE_W'(bus.word_idx), '0);
    check("abort_done", LINE_W'(bus.done), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_line_ready", LINE_W'(bus.line_ready), LINE_W'(1));
    repeat (5) cycle();

    // 50-cycle stall on word 0
    l = rand_line();
    l[WORD_W-1:0] = 32'hDEADBEEF;
    bus.line_in = l;
    bus.line_valid = 1'b1;
    bus.word_ready = 1'b0;
    cycle();
    bus.line_valid = 1'b0;
    repeat (50) cycle();
    check("stall_word_out", LINE_W'(bus.word_out), LINE_W'(32'hDEADBEEF));
    check("stall_line_ready", LINE_W'(bus.line_ready), '0);
    bus.word_ready = 1'b1;
    repeat (10) cycle();

    // Random traffic
    repeat (400) begin
      bus.line_in = rand_line();
      bus.line_valid = 1'($urandom_range(0, 1));
      bus.word_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.line_valid = 1'b0;
    bus.word_ready = 1'b1;
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
